// File: rtl/soc_test_checker_pkg.sv
// Shared types and constants for the CPU6 end-of-test checker.
package soc_test_checker_pkg;

  // Largest supported number of compare channels; first_fail is 4 bits wide.
  localparam int CHK_MAXCH = 16;
  localparam int CHK_IDX_W = 4;

  // Checker FSM states (2-bit encoding shared with benches and debug taps).
  typedef enum logic [1:0] {
    CHK_IDLE  = 2'd0,
    CHK_RUN   = 2'd1,
    CHK_CHECK = 2'd2,
    CHK_DONE  = 2'd3
  } chk_state_e;

endpackage

// File: rtl/soc_test_checker_if.sv
// Bus bundle between a test harness (master) and the checker (slave).
// start is a one-cycle pulse with no handshake: it is accepted on every cycle
// it is high, in any state, and always (re)arms the checker. sample_en is a
// plain qualifier; there is no ready/backpressure path in either direction.
interface soc_test_checker_if #(
  parameter int XLEN       = 32,
  parameter int NUM_CHECKS = 4,
  parameter int CNT_W      = 16
);
  import soc_test_checker_pkg::*;

  logic                       sample_en;
  logic                       start;
  logic [XLEN-1:0]            pc;
  logic [XLEN-1:0]            done_pc;
  logic [NUM_CHECKS-1:0]      chk_mask;
  logic [NUM_CHECKS*XLEN-1:0] chk_exp;
  logic [NUM_CHECKS*XLEN-1:0] chk_obs;

  logic                       busy;
  logic                       done;
  logic                       pass;
  logic                       timeout;
  logic [NUM_CHECKS-1:0]      fail_vec;
  logic [CHK_IDX_W-1:0]       first_fail;
  logic [CNT_W-1:0]           cycle_cnt;
  chk_state_e                 state;      // debug view of the FSM

  modport master (
    output sample_en, start, pc, done_pc, chk_mask, chk_exp, chk_obs,
    input  busy, done, pass, timeout, fail_vec, first_fail, cycle_cnt, state
  );

  modport slave (
    input  sample_en, start, pc, done_pc, chk_mask, chk_exp, chk_obs,
    output busy, done, pass, timeout, fail_vec, first_fail, cycle_cnt, state
  );

endinterface

// File: rtl/soc_test_checker_cmp.sv
// Masked value-compare array plus lowest-index priority encoder.
module soc_test_checker_cmp
  import soc_test_checker_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int NUM_CHECKS = 4
) (
  input  logic [NUM_CHECKS*XLEN-1:0] i_obs,
  input  logic [NUM_CHECKS*XLEN-1:0] i_exp,
  input  logic [NUM_CHECKS-1:0]      i_mask,
  output logic [NUM_CHECKS-1:0]      o_fail_vec,
  output logic [CHK_IDX_W-1:0]       o_first_fail
);

  // A channel fails only when it is enabled and its values differ.
  always_comb begin
    o_fail_vec = '0;
    for (int i = 0; i < NUM_CHECKS; i++) begin
      o_fail_vec[i] = i_mask[i] & (i_obs[i*XLEN +: XLEN] != i_exp[i*XLEN +: XLEN]);
    end
  end

  // Scan high to low so the lowest failing index is the last one written.
  always_comb begin
    o_first_fail = '0;
    for (int i = NUM_CHECKS - 1; i >= 0; i--) begin
      if (o_fail_vec[i]) o_first_fail = CHK_IDX_W'(i);
    end
  end

endmodule

// File: rtl/soc_test_checker.sv
// End-of-test checker: waits for the PC to sit on done_pc for HOLD samples,
// then compares register taps against expected values, or times out.
module soc_test_checker
  import soc_test_checker_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int NUM_CHECKS = 4,
  parameter int TIMEOUT    = 4096,
  parameter int HOLD       = 2,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              reset,
  soc_test_checker_if.slave bus
);

  if (NUM_CHECKS > CHK_MAXCH || NUM_CHECKS < 1) begin : g_bad_num_checks
    $error("soc_test_checker: NUM_CHECKS=%0d outside 1..%0d", NUM_CHECKS, CHK_MAXCH);
  end

  // Hold counter only needs to count up to HOLD; it never goes past it.
  localparam int HW = (HOLD < 2) ? 1 : $clog2(HOLD + 1);
  localparam logic [HW-1:0]  LP_HOLD    = HW'(HOLD);
  localparam logic [CNT_W:0] LP_TIMEOUT = (CNT_W + 1)'(TIMEOUT);

  chk_state_e                 r_state;
  chk_state_e                 w_state_next;
  logic [XLEN-1:0]            r_done_pc;
  logic [NUM_CHECKS-1:0]      r_mask;
  logic [NUM_CHECKS*XLEN-1:0] r_exp;
  logic [HW-1:0]              r_hold;
  logic [CNT_W-1:0]           r_cnt;
  logic [NUM_CHECKS-1:0]      r_fail_vec;
  logic [CHK_IDX_W-1:0]       r_first_fail;
  logic                       r_pass;
  logic                       r_timeout;

  logic [HW-1:0]              w_hold_next;
  logic [CNT_W-1:0]           w_cnt_inc;
  logic                       w_hold_hit;
  logic                       w_cnt_hit;
  logic [NUM_CHECKS-1:0]      w_fail_vec;
  logic [CHK_IDX_W-1:0]       w_first_fail;

  soc_test_checker_cmp #(
    .XLEN       (XLEN),
    .NUM_CHECKS (NUM_CHECKS)
  ) u_cmp (
    .i_obs        (bus.chk_obs),
    .i_exp        (r_exp),
    .i_mask       (r_mask),
    .o_fail_vec   (w_fail_vec),
    .o_first_fail (w_first_fail)
  );

  // Candidate values for the current RUN sample: hold run length and
  // saturating cycle count, plus the two exit conditions they produce.
  always_comb begin
    w_hold_next = (bus.pc == r_done_pc) ? r_hold + 1'b1 : '0;
    w_cnt_inc   = (r_cnt == '1) ? r_cnt : r_cnt + 1'b1;
    w_hold_hit  = (w_hold_next == LP_HOLD);
    w_cnt_hit   = ({1'b0, w_cnt_inc} >= LP_TIMEOUT);
  end

  // Next-state logic; start restarts from any state, a PC match beats timeout.
  always_comb begin
    w_state_next = r_state;
    if (bus.start) begin
      w_state_next = CHK_RUN;
    end else begin
      case (r_state)
        CHK_RUN: begin
          if (bus.sample_en) begin
            if (w_hold_hit)     w_state_next = CHK_CHECK;
            else if (w_cnt_hit) w_state_next = CHK_DONE;
          end
        end
        CHK_CHECK: w_state_next = CHK_DONE;
        default:   w_state_next = r_state;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= CHK_IDLE;
    else       r_state <= w_state_next;
  end

  // Latched configuration, counters and result registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_done_pc    <= '0;
      r_mask       <= '0;
      r_exp        <= '0;
      r_hold       <= '0;
      r_cnt        <= '0;
      r_fail_vec   <= '0;
      r_first_fail <= '0;
      r_pass       <= 1'b0;
      r_timeout    <= 1'b0;
    end else if (bus.start) begin
      r_done_pc    <= bus.done_pc;
      r_mask       <= bus.chk_mask;
      r_exp        <= bus.chk_exp;
      r_hold       <= '0;
      r_cnt        <= '0;
      r_fail_vec   <= '0;
      r_first_fail <= '0;
      r_pass       <= 1'b0;
      r_timeout    <= 1'b0;
    end else begin
      case (r_state)
        CHK_RUN: begin
          if (bus.sample_en) begin
            r_cnt  <= w_cnt_inc;
            r_hold <= w_hold_next;
            if (!w_hold_hit && w_cnt_hit) begin
              r_timeout  <= 1'b1;
              r_pass     <= 1'b0;
              r_fail_vec <= '0;
            end
          end
        end
        CHK_CHECK: begin
          // chk_obs is only looked at here; the compare result is registered.
          r_fail_vec   <= w_fail_vec;
          r_first_fail <= w_first_fail;
          r_pass       <= (w_fail_vec == '0) && !r_timeout;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy       = (r_state == CHK_RUN) || (r_state == CHK_CHECK);
  assign bus.done       = (r_state == CHK_DONE);
  assign bus.pass       = r_pass;
  assign bus.timeout    = r_timeout;
  assign bus.fail_vec   = r_fail_vec;
  assign bus.first_fail = r_first_fail;
  assign bus.cycle_cnt  = r_cnt;
  assign bus.state      = r_state;

endmodule

// File: tb/tb_soc_test_checker.sv
// Directed bench for soc_test_checker: a default instance plus a TIMEOUT=8
// instance fed the same inputs.
module tb_soc_test_checker;
  import soc_test_checker_pkg::*;

  localparam int XLEN = 32;
  localparam int NCH  = 4;
  localparam int CW   = 16;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  soc_test_checker_if #(.XLEN(XLEN), .NUM_CHECKS(NCH), .CNT_W(CW)) bus  ();
  soc_test_checker_if #(.XLEN(XLEN), .NUM_CHECKS(NCH), .CNT_W(CW)) bus8 ();

  soc_test_checker #(.XLEN(XLEN), .NUM_CHECKS(NCH), .TIMEOUT(4096), .HOLD(2), .CNT_W(CW))
    u_dut (.clk(clk), .reset(reset), .bus(bus));

  soc_test_checker #(.XLEN(XLEN), .NUM_CHECKS(NCH), .TIMEOUT(8), .HOLD(2), .CNT_W(CW))
    u_dut8 (.clk(clk), .reset(reset), .bus(bus8));

  assign bus8.sample_en = bus.sample_en;
  assign bus8.start     = bus.start;
  assign bus8.pc        = bus.pc;
  assign bus8.done_pc   = bus.done_pc;
  assign bus8.chk_mask  = bus.chk_mask;
  assign bus8.chk_exp   = bus.chk_exp;
  assign bus8.chk_obs   = bus.chk_obs;

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard check point
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Driver tasks: inputs change just after a falling edge and are checked
  // after the following falling edge, i.e. after one rising edge.
  task automatic arm(input logic [31:0] dpc, input logic [NCH-1:0] mask,
                     input logic [NCH*XLEN-1:0] exp);
    bus.start    = 1'b1;
    bus.done_pc  = dpc;
    bus.chk_mask = mask;
    bus.chk_exp  = exp;
    @(negedge clk);
    bus.start    = 1'b0;
  endtask

  task automatic sample(input logic [31:0] pc_val);
    bus.sample_en = 1'b1;
    bus.pc        = pc_val;
    @(negedge clk);
  endtask

  task automatic idle_cycles(input int n);
    bus.sample_en = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    reset         = 1'b1;
    bus.sample_en = 1'b0;
    bus.start     = 1'b0;
    bus.pc        = '0;
    bus.done_pc   = '0;
    bus.chk_mask  = '0;
    bus.chk_exp   = '0;
    bus.chk_obs   = '0;

    // 1. Reset / idle
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_busy",  32'(bus.busy), 0);
    chk("rst_done",  32'(bus.done), 0);
    chk("rst_pass",  32'(bus.pass), 0);
    chk("rst_tmo",   32'(bus.timeout), 0);
    chk("rst_cnt",   32'(bus.cycle_cnt), 0);
    for (int i = 0; i < 4; i++) sample(32'h30);
    chk("idle_state", 32'(bus.state), 32'(CHK_IDLE));
    chk("idle_cnt",   32'(bus.cycle_cnt), 0);
    chk("idle_done",  32'(bus.done), 0);

    // 2. Pass: pc 0x00..0x30 then 0x30 again = 14 samples
    bus.chk_obs = {32'd0, 32'd0, 32'd0, 32'd5};
    arm(32'h30, 4'b0001, {32'd0, 32'd0, 32'd0, 32'd5});
    chk("p_busy0", 32'(bus.busy), 1);
    for (int i = 0; i <= 12; i++) sample(32'(i * 4));
    chk("p_notyet", 32'(bus.state), 32'(CHK_RUN));
    sample(32'h30);
    bus.sample_en = 1'b0;
    chk("p_check",  32'(bus.state), 32'(CHK_CHECK));
    chk("p_ndone",  32'(bus.done), 0);
    @(negedge clk);
    chk("p_done",   32'(bus.done), 1);
    chk("p_busy",   32'(bus.busy), 0);
    chk("p_pass",   32'(bus.pass), 1);
    chk("p_fvec",   32'(bus.fail_vec), 0);
    chk("p_cnt",    32'(bus.cycle_cnt), 14);
    chk("p_tmo",    32'(bus.timeout), 0);
    bus.chk_obs = {32'd0, 32'd0, 32'd0, 32'd6};
    idle_cycles(2);
    chk("p_obs_ign", 32'(bus.pass), 1);

    // 3. Fail: ch2 mismatches (masked in), ch1 mismatches (masked out)
    bus.chk_obs = {32'd3, 32'd7, 32'd2, 32'd5};
    arm(32'h30, 4'b0101, {32'd4, 32'd9, 32'd1, 32'd5});
    chk("f_restart_done", 32'(bus.done), 0);
    chk("f_restart_cnt",  32'(bus.cycle_cnt), 0);
    for (int i = 0; i <= 12; i++) sample(32'(i * 4));
    sample(32'h30);
    idle_cycles(1);
    chk("f_done",  32'(bus.done), 1);
    chk("f_pass",  32'(bus.pass), 0);
    chk("f_fvec",  32'(bus.fail_vec), 32'b0100);
    chk("f_first", 32'(bus.first_fail), 2);
    chk("f_tmo",   32'(bus.timeout), 0);

    // 4. Hold run resets on a non-matching pc
    bus.chk_obs = {32'd0, 32'd0, 32'd0, 32'd5};
    arm(32'h30, 4'b0001, {32'd0, 32'd0, 32'd0, 32'd5});
    sample(32'h00);
    sample(32'h30);
    chk("h_single", 32'(bus.state), 32'(CHK_RUN));
    sample(32'h34);
    sample(32'h30);
    chk("h_broken", 32'(bus.state), 32'(CHK_RUN));
    sample(32'h30);
    chk("h_check",  32'(bus.state), 32'(CHK_CHECK));
    idle_cycles(1);
    chk("h_pass",   32'(bus.pass), 1);
    chk("h_cnt",    32'(bus.cycle_cnt), 5);

    // 5. Timeout (TIMEOUT=8 instance), then match on the 8th sample
    arm(32'h30, 4'b0001, {32'd0, 32'd0, 32'd0, 32'd5});
    for (int i = 0; i < 7; i++) sample(32'h00);
    chk("t_busy7", 32'(bus8.busy), 1);
    chk("t_cnt7",  32'(bus8.cycle_cnt), 7);
    sample(32'h00);
    chk("t_done",  32'(bus8.done), 1);
    chk("t_tmo",   32'(bus8.timeout), 1);
    chk("t_pass",  32'(bus8.pass), 0);
    chk("t_cnt8",  32'(bus8.cycle_cnt), 8);
    chk("t_fvec",  32'(bus8.fail_vec), 0);
    // mask=0 with all observed values wrong must still pass
    bus.chk_obs = {32'd1, 32'd1, 32'd1, 32'd1};
    arm(32'h30, 4'b0000, {32'd2, 32'd2, 32'd2, 32'd2});
    for (int i = 0; i < 6; i++) sample(32'h00);
    sample(32'h30);
    sample(32'h30);
    chk("tie_check", 32'(bus8.state), 32'(CHK_CHECK));
    idle_cycles(1);
    chk("tie_done",  32'(bus8.done), 1);
    chk("tie_tmo",   32'(bus8.timeout), 0);
    chk("tie_pass",  32'(bus8.pass), 1);
    chk("tie_cnt",   32'(bus8.cycle_cnt), 8);

    // 6. Mid-run events
    arm(32'h30, 4'b0001, {32'd0, 32'd0, 32'd0, 32'd5});
    for (int i = 0; i < 3; i++) sample(32'h00);
    bus.pc = 32'h30;
    idle_cycles(5);
    chk("m_frozen", 32'(bus.cycle_cnt), 3);
    chk("m_busy",   32'(bus.busy), 1);
    sample(32'h04);
    chk("m_resume", 32'(bus.cycle_cnt), 4);
    arm(32'h30, 4'b0001, {32'd0, 32'd0, 32'd0, 32'd5});
    chk("m_rst_cnt", 32'(bus.cycle_cnt), 0);
    chk("m_rst_busy", 32'(bus.busy), 1);
    sample(32'h30);
    sample(32'h30);
    bus.sample_en = 1'b0;
    chk("m_in_check", 32'(bus.state), 32'(CHK_CHECK));
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("m_r_state", 32'(bus.state), 32'(CHK_IDLE));
    chk("m_r_busy",  32'(bus.busy), 0);
    chk("m_r_done",  32'(bus.done), 0);
    chk("m_r_pass",  32'(bus.pass), 0);
    chk("m_r_cnt",   32'(bus.cycle_cnt), 0);
    chk("m_r_fvec",  32'(bus.fail_vec), 0);

    // Final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
